hbt: RTL and testbench

- HyperBus target (responder): a synthesizable HyperRAM device model backed by on-chip byte RAM.
- Serves as the far end of the hbc controller's bus in simulation and in FPGA loopback builds (controller pins wired to this block through the board top).
- Runs on the same clk as the controller (2x hyper clock): one DDR bus byte per clk posedge while hpr_csn is low.

---
 rtl/hbt_pkg.sv | 38 +++
 rtl/hbt_ram.sv | 20 ++
 rtl/hbt.sv | 199 +++++++++++++++++++
 tb/tb_hbt.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hbt_pkg.sv
// Shared definitions for the hbt HyperBus target: state encoding, CA field
// positions, register reset values and the CR0 latency-code table.
package hbt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    RDATA,
    WDATA
  } hbt_state_t;

  localparam int CA_RD_BIT     = 47;
  localparam int CA_REG_BIT    = 46;
  localparam int CA_LIN_BIT    = 45;
  localparam int CA_REGSEL_BIT = 24;
  localparam int CA_DIE_BIT    = 0;
  localparam int CA_ROW_LSB    = 16;

  localparam logic [15:0] CR0_RESET = 16'h8f1f;
  localparam logic [15:0] CR1_RESET = 16'h0002;

  // CR0[7:4] code -> latency in hyper clocks; 0 marks an unsupported code.
  function automatic logic [3:0] lat_code_to_n(input logic [3:0] code);
    case (code)
      4'he:    lat_code_to_n = 4'd3;
      4'hf:    lat_code_to_n = 4'd4;
      4'h0:    lat_code_to_n = 4'd5;
      4'h1:    lat_code_to_n = 4'd6;
      default: lat_code_to_n = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] n_to_lat_cyc(input logic [3:0] n);
    n_to_lat_cyc = {2'b00, n, 2'b00} - 8'd2;
  endfunction

endpackage

// File: rtl/hbt_ram.sv
// Byte-wide backing RAM for the hbt target: one write port, one registered read port.
module hbt_ram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hbt.sv
// HyperBus target (HyperRAM model) backed by hbt_ram. Optional macro
// HBT_WRAP_BURST_EN enables 16-word wrapped bursts for CA linear=0.
module hbt
  import hbt_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 14,
  parameter int          DEFAULT_LATENCY = 6,
  parameter logic [15:0] ID0_VALUE       = 16'h0c81,
  parameter logic [15:0] ID1_VALUE       = 16'h0001
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       hpr_csn,
  input  logic [7:0] hpr_dq_i,
  output logic [7:0] hpr_dq_o,
  output logic       hpr_dq_oe,
  input  logic       hpr_rwds_i,
  output logic       hpr_rwds_o,
  output logic       hpr_rwds_oe,
  output logic [7:0] lat_cyc
);

  localparam int              WA_W      = ADDR_WIDTH - 1;
  localparam logic [7:0]      LAT_RESET = 8'(DEFAULT_LATENCY * 4 - 2);
  localparam logic [WA_W-1:0] WA_ONE    = WA_W'(1);

  hbt_state_t state, state_nxt;

  logic [39:0]           ca_sr;
  logic [2:0]            ca_cnt;
  logic [47:0]           ca_full;
  logic [WA_W-1:0]       ca_word;
  logic                  unused_ca;
  logic                  ca_last;
  logic                  is_rd, is_reg, sel_cr, sel_die;
`ifdef HBT_WRAP_BURST_EN
  logic                  is_lin;
`endif
  logic [7:0]            lat_cnt;
  logic [WA_W-1:0]       waddr, waddr_inc;
  logic                  hi, fetch_hi_q;
  logic [7:0]            reg_lo;
  logic                  reg_done;
  logic [15:0]           cr0, cr1, reg_val;
  logic [3:0]            new_n;
  logic                  fetch, wr_byte, ram_we;
  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [7:0]            ram_rdata, rd_byte;

  // The sixth CA byte is used live from the bus so decode happens on that edge.
  assign ca_full   = {ca_sr, hpr_dq_i};
  assign ca_word   = {ca_full[CA_ROW_LSB +: WA_W-3], ca_full[2:0]};
  assign unused_ca = ^ca_full;
  assign ca_last   = (state == CA) && (ca_cnt == 3'd5);

  assign fetch     = !hpr_csn && is_rd &&
                     (((state == LAT) && (lat_cnt == 8'd0)) || (state == RDATA));
  assign wr_byte   = !hpr_csn && (state == WDATA) && !is_reg;
  assign ram_we    = wr_byte && !hpr_rwds_i;
  assign byte_addr = {waddr, hi};

  assign reg_val = sel_cr ? (sel_die ? cr1 : cr0) : (sel_die ? ID1_VALUE : ID0_VALUE);
  assign rd_byte = is_reg ? (fetch_hi_q ? reg_val[15:8] : reg_val[7:0]) : ram_rdata;
  assign new_n   = lat_code_to_n(reg_lo[7:4]);

  always_comb begin
    waddr_inc = waddr + WA_ONE;
`ifdef HBT_WRAP_BURST_EN
    if (!is_lin) waddr_inc = {waddr[WA_W-1:4], waddr[3:0] + 4'd1};
`endif
  end

  always_comb begin
    state_nxt = state;
    if (hpr_csn) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CA;
        CA: begin
          if (ca_last)
            state_nxt = (ca_full[CA_REG_BIT] && !ca_full[CA_RD_BIT]) ? WDATA : LAT;
        end
        LAT: begin
          if (lat_cnt == 8'd0) state_nxt = is_rd ? RDATA : WDATA;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // lat_cnt is preloaded with lat_cyc-2 so the data phase lines up exactly
  // lat_cyc clocks after the last CA byte, with one clock of RAM prefetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ca_sr       <= '0;
      ca_cnt      <= '0;
      is_rd       <= 1'b0;
      is_reg      <= 1'b0;
      sel_cr      <= 1'b0;
      sel_die     <= 1'b0;
`ifdef HBT_WRAP_BURST_EN
      is_lin      <= 1'b1;
`endif
      lat_cnt     <= '0;
      waddr       <= '0;
      hi          <= 1'b0;
      fetch_hi_q  <= 1'b0;
      reg_lo      <= '0;
      reg_done    <= 1'b0;
      cr0         <= CR0_RESET;
      cr1         <= CR1_RESET;
      lat_cyc     <= LAT_RESET;
      hpr_dq_o    <= '0;
      hpr_dq_oe   <= 1'b0;
      hpr_rwds_o  <= 1'b0;
      hpr_rwds_oe <= 1'b0;
    end else if (hpr_csn) begin
      ca_cnt      <= '0;
      hpr_dq_o    <= '0;
      hpr_dq_oe   <= 1'b0;
      hpr_rwds_o  <= 1'b0;
      hpr_rwds_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ca_sr  <= {ca_sr[31:0], hpr_dq_i};
          ca_cnt <= 3'd1;
        end
        CA: begin
          ca_sr  <= {ca_sr[31:0], hpr_dq_i};
          ca_cnt <= ca_cnt + 3'd1;
          if (ca_last) begin
            is_rd    <= ca_full[CA_RD_BIT];
            is_reg   <= ca_full[CA_REG_BIT];
            sel_cr   <= ca_full[CA_REGSEL_BIT];
            sel_die  <= ca_full[CA_DIE_BIT];
`ifdef HBT_WRAP_BURST_EN
            is_lin   <= ca_full[CA_LIN_BIT];
`endif
            waddr    <= ca_word;
            hi       <= 1'b0;
            reg_done <= 1'b0;
            lat_cnt  <= lat_cyc - 8'd2;
          end
        end
        LAT: begin
          if (lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
        end
        RDATA: begin
          hpr_dq_oe   <= 1'b1;
          hpr_rwds_oe <= 1'b1;
          hpr_dq_o    <= rd_byte;
          hpr_rwds_o  <= ~fetch_hi_q;
        end
        WDATA: begin
          if (is_reg && !reg_done) begin
            if (!hi) begin
              reg_lo <= hpr_dq_i;
              hi     <= 1'b1;
            end else begin
              reg_done <= 1'b1;
              if (sel_cr && !sel_die) begin
                cr0 <= {hpr_dq_i, reg_lo};
                if (new_n != 4'd0) lat_cyc <= n_to_lat_cyc(new_n);
              end else if (sel_cr) begin
                cr1 <= {hpr_dq_i, reg_lo};
              end
            end
          end
        end
        default: ;
      endcase

      if (fetch || wr_byte) begin
        hi         <= ~hi;
        fetch_hi_q <= hi;
        if (hi) waddr <= waddr_inc;
      end
    end
  end

  hbt_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (byte_addr),
    .wdata (hpr_dq_i),
    .raddr (byte_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_hbt.sv
// Self-checking bench for hbt: directed bus transactions, read bytes checked
// against a scoreboard of expected (cycle, data, rwds) entries.
module tb_hbt;

  localparam int ADDR_WIDTH = 14;
  localparam int RAM_WORDS  = 2 ** (ADDR_WIDTH - 1);

  logic       clk = 1'b0;
  logic       resetn;
  logic       hpr_csn;
  logic [7:0] hpr_dq_i;
  logic [7:0] hpr_dq_o;
  logic       hpr_dq_oe;
  logic       hpr_rwds_i;
  logic       hpr_rwds_o;
  logic       hpr_rwds_oe;
  logic [7:0] lat_cyc;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  dq;
    logic        rwds;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model [2**ADDR_WIDTH];
  int unsigned cyc = 0;
  int unsigned last_ca_cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          rd_idx = 0;
  int          model_lat = 22;

  hbt dut (
    .clk         (clk),
    .resetn      (resetn),
    .hpr_csn     (hpr_csn),
    .hpr_dq_i    (hpr_dq_i),
    .hpr_dq_o    (hpr_dq_o),
    .hpr_dq_oe   (hpr_dq_oe),
    .hpr_rwds_i  (hpr_rwds_i),
    .hpr_rwds_o  (hpr_rwds_o),
    .hpr_rwds_oe (hpr_rwds_oe),
    .lat_cyc     (lat_cyc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic csn, input logic [7:0] dq, input logic rwds);
    @(negedge clk);
    hpr_csn    = csn;
    hpr_dq_i   = dq;
    hpr_rwds_i = rwds;
  endtask

  function automatic logic [47:0] mkCa(input logic rd, input logic rg, input logic lin,
                                       input logic [31:0] w);
    mkCa = {rd, rg, lin, w[31:3], 13'd0, w[2:0]};
  endfunction

  function automatic logic [31:0] nextWord(input logic [31:0] w, input logic lin);
    logic [31:0] n;
    n = (w + 1) % RAM_WORDS;
`ifdef HBT_WRAP_BURST_EN
    if (!lin) n = {w[31:4], w[3:0] + 4'd1};
`endif
    return n;
  endfunction

  // Every driven read byte must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1 && hpr_dq_oe === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_oe", {31'd0, hpr_dq_oe}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput($sformatf("rd%0d_cyc", rd_idx), cyc, e.cyc);
        checkOutput($sformatf("rd%0d_dq", rd_idx), {24'd0, hpr_dq_o}, {24'd0, e.dq});
        checkOutput($sformatf("rd%0d_rwds", rd_idx), {31'd0, hpr_rwds_o}, {31'd0, e.rwds});
        checkOutput($sformatf("rd%0d_rwds_oe", rd_idx), {31'd0, hpr_rwds_oe}, 32'd1);
        rd_idx++;
      end
    end
  end

  task automatic sendCa(input logic [47:0] ca);
    for (int i = 5; i >= 0; i--) applyStimulus(1'b0, ca[i*8 +: 8], 1'b0);
    last_ca_cyc = cyc + 1;
  endtask

  task automatic endBurst();
    applyStimulus(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("oe_drop", {30'd0, hpr_dq_oe, hpr_rwds_oe}, 32'd0);
  endtask

  task automatic pushRead(input logic [31:0] w0, input logic lin, input int n);
    logic [31:0] w;
    exp_t e;
    w = w0;
    for (int i = 0; i < n; i++) begin
      e.cyc  = last_ca_cyc + model_lat + i;
      e.dq   = model[w*2 + i%2];
      e.rwds = (i % 2 == 0);
      sb.push_back(e);
      if (i % 2 == 1) w = nextWord(w, lin);
    end
  endtask

  task automatic doRead(input logic [31:0] w0, input logic lin, input int n);
    sendCa(mkCa(1'b1, 1'b0, lin, w0));
    pushRead(w0, lin, n);
    repeat (model_lat + n - 1) applyStimulus(1'b0, 8'h00, 1'b0);
    endBurst();
    checkOutput("sb_drain", sb.size(), 32'd0);
  endtask

  task automatic doWrite(input logic [31:0] w0, input logic lin, input logic [31:0] data,
                         input logic [3:0] mask, input int n);
    logic [31:0] w;
    sendCa(mkCa(1'b0, 1'b0, lin, w0));
    repeat (model_lat - 1) applyStimulus(1'b0, 8'hEE, 1'b0);
    w = w0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, data[i*8 +: 8], mask[i]);
      if (!mask[i]) model[w*2 + i%2] = data[i*8 +: 8];
      if (i % 2 == 1) w = nextWord(w, lin);
    end
    endBurst();
  endtask

  task automatic doRegWrite(input logic [31:0] w, input logic [15:0] value);
    sendCa(mkCa(1'b0, 1'b1, 1'b1, w));
    applyStimulus(1'b0, value[7:0], 1'b0);
    applyStimulus(1'b0, value[15:8], 1'b0);
    endBurst();
  endtask

  task automatic doRegRead(input logic [31:0] w, input logic [15:0] value, input int n);
    exp_t e;
    sendCa(mkCa(1'b1, 1'b1, 1'b1, w));
    for (int i = 0; i < n; i++) begin
      e.cyc  = last_ca_cyc + model_lat + i;
      e.dq   = (i % 2 == 0) ? value[7:0] : value[15:8];
      e.rwds = (i % 2 == 0);
      sb.push_back(e);
    end
    repeat (model_lat + n - 1) applyStimulus(1'b0, 8'h00, 1'b0);
    endBurst();
    checkOutput("reg_sb_drain", sb.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn     = 1'b0;
    hpr_csn    = 1'b1;
    hpr_dq_i   = 8'h00;
    hpr_rwds_i = 1'b0;
    #12;
    checkOutput("rst_dq_o", {24'd0, hpr_dq_o}, 32'd0);
    checkOutput("rst_dq_oe", {31'd0, hpr_dq_oe}, 32'd0);
    checkOutput("rst_rwds_o", {31'd0, hpr_rwds_o}, 32'd0);
    checkOutput("rst_rwds_oe", {31'd0, hpr_rwds_oe}, 32'd0);
    checkOutput("rst_lat_cyc", {24'd0, lat_cyc}, 32'd22);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b0);

    // Known contents under the byte that the masked write must leave alone.
    doWrite(32'd2, 1'b1, 32'h00005aa5, 4'b0000, 2);
    doWrite(32'd1, 1'b1, 32'h44332211, 4'b0100, 4);
    doRead(32'd1, 1'b1, 4);

    // CR0 latency code 0xE -> 3 hyper clocks -> 10 clk.
    doRegWrite(32'h800, 16'h8fef);
    checkOutput("lat_after_cr0", {24'd0, lat_cyc}, 32'd10);
    model_lat = 10;
    doRegRead(32'h800, 16'h8fef, 4);
    doRegRead(32'h000, 16'h0c81, 2);
    doRegRead(32'h001, 16'h0001, 2);
    doRegRead(32'h801, 16'h0002, 2);

    // Register write cut after its first byte changes nothing.
    sendCa(mkCa(1'b0, 1'b1, 1'b1, 32'h800));
    applyStimulus(1'b0, 8'h1f, 1'b0);
    endBurst();
    checkOutput("lat_partial_reg", {24'd0, lat_cyc}, 32'd10);
    doRegRead(32'h800, 16'h8fef, 2);

    // Abandoned CA followed by a complete write.
    applyStimulus(1'b0, 8'h20, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    endBurst();
    doWrite(32'd8, 1'b1, 32'hc33cc55c, 4'b0000, 4);
    doRead(32'd8, 1'b1, 4);

    // Linear burst off the top of RAM wraps to word 0.
    doWrite(RAM_WORDS - 1, 1'b1, 32'h74737271, 4'b0000, 4);
    doRead(32'd0, 1'b1, 2);
    doRead(RAM_WORDS - 1, 1'b1, 2);

    // Read across the 16-word group boundary with linear=0.
    doWrite(32'd15, 1'b1, 32'h84838281, 4'b0000, 4);
    doRead(32'd15, 1'b0, 4);

    // Asynchronous reset in the middle of a read burst.
    sendCa(mkCa(1'b1, 1'b0, 1'b1, 32'd1));
    pushRead(32'd1, 1'b1, 4);
    repeat (model_lat + 1) applyStimulus(1'b0, 8'h00, 1'b0);
    #2;
    resetn  = 1'b0;
    hpr_csn = 1'b1;
    #1;
    checkOutput("midrst_dq_oe", {31'd0, hpr_dq_oe}, 32'd0);
    checkOutput("midrst_rwds_oe", {31'd0, hpr_rwds_oe}, 32'd0);
    checkOutput("midrst_dq_o", {24'd0, hpr_dq_o}, 32'd0);
    checkOutput("midrst_lat_cyc", {24'd0, lat_cyc}, 32'd22);
    sb.delete();
    model_lat = 22;
    @(negedge clk);
    #2;
    resetn = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b0);
    doRead(32'd1, 1'b1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
